serial_alu_seq: RTL and testbench
=================================

// Module: serial_alu_seq
// PURPOSE
//  Bit-serial sequencer for the 1-bit ALU slice. Accepts WIDTH-bit operands and a 3-bit op via
//  valid/ready, feeds the slice one bit per cycle LSB-first, and registers carry between bits.
//  Assembles the WIDTH-bit result and flags, then holds them until the consumer accepts.
//  Sits between the register-read stage (upstream) and the slice (downstream, combinational).
// PARAMETERS
//  WIDTH  8  operand/result width in bits (>=2)
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      asynchronous, active-low reset
//  start_valid  in   1      op_a/op_b/alu_op valid
//  start_ready  out  1      sequencer can accept (IDLE only)
//  op_a         in   WIDTH  operand A
//  op_b         in   WIDTH  operand B
//  alu_op       in   3      000 MOV, 001 NOT, 010 ADD, 101 SUB, 100 OR, 011 AND
//  slice_a      out  1      current A bit to slice
//  slice_b      out  1      current B bit to slice
//  slice_cin    out  1      carry into current bit
//  slice_op     out  3      latched op to slice
//  slice_result in   1      slice result bit
//  slice_cout   in   1      slice carry out
//  result       out  WIDTH  assembled result
//  carry_out    out  1      final carry (ADD/SUB only, else 0)
//  overflow     out  1      signed overflow (ADD/SUB only, else 0)
//  zero         out  1      result == 0
//  done_valid   out  1      result/flags valid
//  done_ready   in   1      consumer accepts result
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; result, carry_out, overflow, done_valid,
//    slice_a, slice_b, slice_cin, slice_op, bit counter, shift regs all 0; zero=1.
//  - FSM IDLE -> RUN -> DONE -> IDLE.
//  - IDLE: start_ready=1. On start_valid: latch op_a/op_b into shift regs, alu_op into op reg,
//    counter=0, carry reg = (alu_op==101). -> RUN.
//  - RUN (exactly WIDTH cycles): slice_a/slice_b = shift-reg bit0, slice_cin = carry reg,
//    slice_op = op reg. Each edge: result shifts right with slice_result into MSB;
//    carry<=slice_cout; operand regs shift right; counter++. Before the last bit's edge, save
//    carry reg as c_msb_in. After bit WIDTH-1 -> DONE.
//  - DONE: done_valid=1; result and flags held stable. carry_out = final carry if op is ADD/SUB,
//    else 0; overflow = c_msb_in XOR final carry if ADD/SUB, else 0; zero = (result==0).
//    done_ready=1 -> IDLE next edge; done_valid drops that edge.
//  - Latency: accept edge to done_valid high = WIDTH+1 edges; min issue interval WIDTH+2 cycles.
//  - start_ready=0 in RUN/DONE; start_valid ignored there (no queuing, no back-to-back).
//  - done_ready outside DONE is ignored. Undefined ops 110/111 are passed to the slice
//    unchanged; flags carry_out/overflow forced 0.
//  - Reset mid-RUN/DONE aborts the op; nothing is emitted; the next accepted op is exact.
//  - Slice outputs are registered values; slice is combinational, one bit per cycle.
// TESTING (WIDTH=8, real slice connected)
//  ADD 0x7F+0x01 -> result 0x80, carry_out 0, overflow 1, zero 0; done_valid 9 edges after accept.
//  SUB 0x05-0x05 -> 0x00, carry_out 1, zero 1; SUB 0x03-0x05 -> 0xFE, carry_out 0, overflow 0.
//  AND 0xF0,0x3C -> 0x30; OR -> 0xFC; MOV 0xA5 -> 0xA5; NOT 0xA5 -> 0x5A; carry/overflow 0.
//  done_ready low 5 cycles in DONE -> result/flags stable, start_ready 0, start_valid ignored.
//  rst_n low after 3 RUN bits -> all outputs at reset values; then ADD 0xFF+0x01 -> 0x00, carry 1.
//  Random 1000 ops, random start_valid/done_ready gaps vs. golden model -> exact match.

Source files
------------

// File: rtl/serial_alu_seq.sv
// serial_alu_seq
// Bit-serial sequencer wrapped around an external, purely combinational
// 1-bit ALU slice. A WIDTH-bit operation is accepted over a valid/ready
// handshake and fed to the slice one bit per cycle, least significant bit
// first, with the carry registered between bits. Once all WIDTH bits have
// been processed, the assembled result and its flags are held until the
// consumer accepts them.
//
// Handshake / timing summary:
//   - IDLE accepts a new operation (start_ready=1).
//   - RUN lasts exactly WIDTH cycles, one slice evaluation per cycle.
//   - DONE presents result/flags with done_valid=1 until done_ready.
// Counting the accept edge itself, done_valid rises WIDTH+1 edges after
// acceptance. The minimum issue interval is WIDTH+2 cycles.

module serial_alu_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,

   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic [2:0]       alu_op,

   output logic             slice_a,
   output logic             slice_b,
   output logic             slice_cin,
   output logic [2:0]       slice_op,
   input  logic             slice_result,
   input  logic             slice_cout,

   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             overflow,
   output logic             zero,
   output logic             done_valid,
   input  logic             done_ready
);

   // Width of the bit counter. WIDTH is at least 2, so this is at least 1.
   localparam int CW = $clog2(WIDTH);

   // Opcodes that produce meaningful carry and overflow flags.
   // SUB relies on the slice computing a + ~b + cin, with cin seeded to 1.
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] aShift_q;
   logic [WIDTH-1:0] bShift_q;
   logic [WIDTH-1:0] result_q;
   logic [2:0]       op_q;
   logic [CW-1:0]    cnt_q;
   logic             carry_q;
   logic             carryOut_q;
   logic             overflow_q;

   logic             lastBit_d;
   logic             isArith_d;
   logic [WIDTH-1:0] resultNext_d;
   logic             carryOutNext_d;
   logic             overflowNext_d;

   // Per-cycle decode: detect the final bit, classify the latched op, and
   // form the next result word and flag values.
   // During the last RUN cycle, carry_q holds the carry into the MSB. Its
   // XOR with the slice's carry out therefore gives signed overflow.
   always_comb begin
      lastBit_d      = (cnt_q == CW'(WIDTH - 1));
      isArith_d      = (op_q == OP_ADD) || (op_q == OP_SUB);
      resultNext_d   = {slice_result, result_q[WIDTH-1:1]};
      carryOutNext_d = 1'b0;
      overflowNext_d = 1'b0;
      if (isArith_d) begin
         carryOutNext_d = slice_cout;
         overflowNext_d = carry_q ^ slice_cout;
      end
   end

   // Sequencer FSM and datapath registers.
   // Reset clears everything, so an aborted operation leaves no trace.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         aShift_q   <= '0;
         bShift_q   <= '0;
         result_q   <= '0;
         op_q       <= 3'b000;
         cnt_q      <= '0;
         carry_q    <= 1'b0;
         carryOut_q <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_valid) begin
                  aShift_q   <= op_a;
                  bShift_q   <= op_b;
                  op_q       <= alu_op;
                  cnt_q      <= '0;
                  carry_q    <= (alu_op == OP_SUB);
                  result_q   <= '0;
                  carryOut_q <= 1'b0;
                  overflow_q <= 1'b0;
                  state_q    <= RUN;
               end
            end
            RUN: begin
               result_q <= resultNext_d;
               carry_q  <= slice_cout;
               aShift_q <= aShift_q >> 1;
               bShift_q <= bShift_q >> 1;
               cnt_q    <= cnt_q + CW'(1);
               if (lastBit_d) begin
                  carryOut_q <= carryOutNext_d;
                  overflow_q <= overflowNext_d;
                  state_q    <= DONE;
               end
            end
            DONE: begin
               if (done_ready) begin
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Drive the slice directly from register bits, so its inputs are clean.
   assign slice_a     = aShift_q[0];
   assign slice_b     = bShift_q[0];
   assign slice_cin   = carry_q;
   assign slice_op    = op_q;

   // Handshakes are state decodes. The result and flags come from registers.
   assign start_ready = (state_q == IDLE);
   assign done_valid  = (state_q == DONE);
   assign result      = result_q;
   assign carry_out   = carryOut_q;
   assign overflow    = overflow_q;
   assign zero        = (result_q == '0);

endmodule

// File: tb/tb_serial_alu_seq.sv
// tb_serial_alu_seq
// Drives serial_alu_seq with a behavioural 1-bit slice attached and checks
// results and flags against a word-level golden model. Expected values are
// pushed to a scoreboard queue when an operation is accepted, and popped
// when the DUT presents its result.

module tb_serial_alu_seq;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start_valid = 1'b0;
   logic             start_ready;
   logic [WIDTH-1:0] op_a = '0;
   logic [WIDTH-1:0] op_b = '0;
   logic [2:0]       alu_op = 3'b000;
   logic             slice_a;
   logic             slice_b;
   logic             slice_cin;
   logic [2:0]       slice_op;
   logic             slice_result;
   logic             slice_cout;
   logic [WIDTH-1:0] result;
   logic             carry_out;
   logic             overflow;
   logic             zero;
   logic             done_valid;
   logic             done_ready = 1'b0;

   typedef struct packed {
      logic [WIDTH-1:0] res;
      logic             c;
      logic             v;
      logic             z;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;

   // Free-running clock with a 10-time-unit period.
   always #5 clk = ~clk;

   serial_alu_seq #(.WIDTH(WIDTH)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start_valid  (start_valid),
      .start_ready  (start_ready),
      .op_a         (op_a),
      .op_b         (op_b),
      .alu_op       (alu_op),
      .slice_a      (slice_a),
      .slice_b      (slice_b),
      .slice_cin    (slice_cin),
      .slice_op     (slice_op),
      .slice_result (slice_result),
      .slice_cout   (slice_cout),
      .result       (result),
      .carry_out    (carry_out),
      .overflow     (overflow),
      .zero         (zero),
      .done_valid   (done_valid),
      .done_ready   (done_ready)
   );

   // Combinational 1-bit ALU slice.
   // SUB computes a + ~b + cin, and the undefined ops produce a ^ b.
   always_comb begin
      slice_result = 1'b0;
      slice_cout   = 1'b0;
      case (slice_op)
         3'b000: slice_result = slice_a;
         3'b001: slice_result = ~slice_a;
         3'b010: begin
            slice_result = slice_a ^ slice_b ^ slice_cin;
            slice_cout   = (slice_a & slice_b) | (slice_a & slice_cin) | (slice_b & slice_cin);
         end
         3'b101: begin
            slice_result = slice_a ^ ~slice_b ^ slice_cin;
            slice_cout   = (slice_a & ~slice_b) | (slice_a & slice_cin) | (~slice_b & slice_cin);
         end
         3'b100: slice_result = slice_a | slice_b;
         3'b011: slice_result = slice_a & slice_b;
         default: slice_result = slice_a ^ slice_b;
      endcase
   end

   // Word-level reference model for one complete operation.
   function automatic exp_t golden(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                   input logic [WIDTH-1:0] b);
      exp_t           e;
      logic [WIDTH:0] s;
      e = '0;
      s = '0;
      case (op)
         3'b000: e.res = a;
         3'b001: e.res = ~a;
         3'b010: begin
            s     = {1'b0, a} + {1'b0, b};
            e.res = s[WIDTH-1:0];
            e.c   = s[WIDTH];
            e.v   = (a[WIDTH-1] == b[WIDTH-1]) && (e.res[WIDTH-1] != a[WIDTH-1]);
         end
         3'b101: begin
            s     = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
            e.res = s[WIDTH-1:0];
            e.c   = s[WIDTH];
            e.v   = (a[WIDTH-1] != b[WIDTH-1]) && (e.res[WIDTH-1] != a[WIDTH-1]);
         end
         3'b100: e.res = a | b;
         3'b011: e.res = a & b;
         default: e.res = a ^ b;
      endcase
      e.z = (e.res == '0);
      return e;
   endfunction

   // Compare one observed value against its expectation, and count the result.
   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Present an operation after `gap` idle cycles and wait for it to be
   // accepted. On acceptance, push its expected outcome to the scoreboard.
   task automatic applyStimulus(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                input logic [WIDTH-1:0] b, input int gap);
      logic rdy;
      logic accepted;
      accepted = 1'b0;
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
      start_valid = 1'b1;
      op_a        = a;
      op_b        = b;
      alu_op      = op;
      for (int i = 0; i < 50 && !accepted; i++) begin
         rdy = start_ready;
         @(posedge clk);
         #1;
         if (rdy) accepted = 1'b1;
      end
      start_valid = 1'b0;
      checkVal("accept", 32'(accepted), 32'd1);
      if (accepted) sb.push_back(golden(op, a, b));
   endtask

   // Wait for done_valid, optionally checking latency. Stall the consumer for
   // `hold` cycles while sending ignored starts, then accept the result and
   // compare it against the scoreboard.
   task automatic checkOutput(input int hold, input bit checkLatency);
      exp_t             e;
      int               edges;
      logic [WIDTH-1:0] heldRes;
      logic             heldC;
      logic             heldV;
      edges = 0;
      while (!done_valid && edges < 100) begin
         @(posedge clk);
         #1;
         edges++;
      end
      checkVal("done_timeout", 32'(done_valid), 32'd1);
      if (checkLatency) checkVal("latency_edges_incl_accept", 32'(edges + 1), 32'(WIDTH + 1));
      heldRes = result;
      heldC   = carry_out;
      heldV   = overflow;
      repeat (hold) begin
         start_valid = 1'b1;
         op_a        = 8'($urandom);
         op_b        = 8'($urandom);
         alu_op      = 3'b010;
         @(posedge clk);
         #1;
         checkVal("hold_result", 32'(result), 32'(heldRes));
         checkVal("hold_flags", 32'({carry_out, overflow}), 32'({heldC, heldV}));
         checkVal("hold_start_ready", 32'(start_ready), 32'd0);
         checkVal("hold_done_valid", 32'(done_valid), 32'd1);
      end
      start_valid = 1'b0;
      done_ready  = 1'b1;
      checkVal("scoreboard_nonempty", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         checkVal("result", 32'(result), 32'(e.res));
         checkVal("carry_out", 32'(carry_out), 32'(e.c));
         checkVal("overflow", 32'(overflow), 32'(e.v));
         checkVal("zero", 32'(zero), 32'(e.z));
      end
      @(posedge clk);
      #1;
      done_ready = 1'b0;
      checkVal("done_valid_drop", 32'(done_valid), 32'd0);
      checkVal("start_ready_back", 32'(start_ready), 32'd1);
   endtask

   // Check that every output sits at its reset value.
   task automatic checkResetState(input string tag);
      checkVal({tag, "_result"}, 32'(result), 32'd0);
      checkVal({tag, "_flags"}, 32'({carry_out, overflow, zero}), 32'b001);
      checkVal({tag, "_handshake"}, 32'({done_valid, start_ready}), 32'b01);
      checkVal({tag, "_slice"}, 32'({slice_a, slice_b, slice_cin, slice_op}), 32'd0);
   endtask

   // Directed sequence first, then a randomized run against the golden model.
   initial begin
      repeat (2) @(posedge clk);
      #1;
      checkResetState("reset");
      rst_n = 1'b1;

      // ADD with signed overflow, including the latency check.
      applyStimulus(3'b010, 8'h7F, 8'h01, 1);
      checkVal("run_slice_op_add", 32'(slice_op), 32'(3'b010));
      checkOutput(0, 1'b1);

      // SUB with equal operands, then SUB with a borrow.
      applyStimulus(3'b101, 8'h05, 8'h05, 0);
      checkOutput(0, 1'b1);
      applyStimulus(3'b101, 8'h03, 8'h05, 0);
      checkVal("run_slice_sub_bit0", 32'({slice_a, slice_b, slice_cin, slice_op}),
               32'({1'b1, 1'b1, 1'b1, 3'b101}));
      checkOutput(0, 1'b1);

      // Logic operations, with a stalled consumer on the OR.
      applyStimulus(3'b011, 8'hF0, 8'h3C, 0);
      checkOutput(0, 1'b1);
      applyStimulus(3'b100, 8'hF0, 8'h3C, 0);
      checkOutput(5, 1'b1);
      applyStimulus(3'b000, 8'hA5, 8'h00, 2);
      checkOutput(0, 1'b1);
      applyStimulus(3'b001, 8'hA5, 8'h00, 0);
      checkOutput(0, 1'b1);
      applyStimulus(3'b110, 8'hFF, 8'hFF, 0);
      checkOutput(1, 1'b1);

      // Asynchronous reset after three RUN bits aborts the operation.
      applyStimulus(3'b010, 8'h55, 8'hAA, 0);
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      rst_n = 1'b0;
      #1;
      checkResetState("midrun_reset");
      void'(sb.pop_back());
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      applyStimulus(3'b010, 8'hFF, 8'h01, 1);
      checkOutput(0, 1'b1);

      // Randomized operations with random start gaps and consumer stalls.
      for (int n = 0; n < 1000; n++) begin
         applyStimulus(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
                       int'($urandom_range(0, 3)));
         checkOutput(int'($urandom_range(0, 3)), 1'b1);
      end

      checkVal("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
